// File: rtl/calc_core_n.sv
// Keypad-driven four-function decimal calculator core: operand entry, iterative
// restoring divider, double-dabble conversion and an eight-digit code display.
module calc_core_n #(
  parameter int DIGITS = 2,
  parameter int RW     = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_pulse,
  input  logic [3:0]  key_code,
  output logic [39:0] seg_data,
  output logic [7:0]  seg_data_en,
  output logic [7:0]  seg_dot_en,
  output logic        busy,
  output logic        err
);
  localparam int OW = 14;
  localparam int ND = (RW + 2) / 3;
  localparam int BW = 4 * ND;
  localparam int EW = 4 * DIGITS;
  localparam int CW = $clog2(RW) + 1;
  localparam logic [OW-1:0] TEN = OW'(10);
  localparam logic [39:0] BLANKS = {8{5'd16}};

  typedef enum logic [2:0] {IDLE, OPA, OP, OPB, CALC, CONV, SHOW, ERR} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [OW-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [EW-1:0] ent_q, ent_d;
  logic [RW-1:0] res_q, res_d, rem_q, rem_d;
  logic          neg_q, neg_d;
  logic [BW-1:0] bcd_q, bcd_d;
  logic [CW-1:0] step_q, step_d;
  logic [39:0]   seg_q, seg_d;
  logic          busy_q, busy_d, err_q, err_d;

  logic          key_digit, key_op, key_eq, key_clr;
  logic [RW:0]   rem_sh;
  logic [BW-1:0] bcd_adj;
  logic [RW-1:0] b_ext;
  logic [31:0]   ent_pad;
  int            msd;

  assign key_digit = key_pulse && (key_code <= 4'd9);
  assign key_op    = key_pulse && (key_code >= 4'ha) && (key_code <= 4'hd);
  assign key_eq    = key_pulse && (key_code == 4'he);
  assign key_clr   = key_pulse && (key_code == 4'hf);
  assign b_ext     = RW'(b_q);
  assign ent_pad   = 32'(ent_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    ent_d   = ent_q;
    res_d   = res_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    step_d  = step_q;

    rem_sh = {rem_q, res_q[RW-1]};
    for (int i = 0; i < ND; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end

    case (state_q)
      IDLE, SHOW: begin
        if (key_digit) begin
          a_d     = OW'(key_code);
          b_d     = '0;
          ent_d   = EW'(key_code);
          cnt_d   = 3'd1;
          neg_d   = 1'b0;
          state_d = OPA;
        end
      end
      OPA: begin
        if (key_digit) begin
          if (cnt_q < 3'(DIGITS)) begin
            a_d   = a_q * TEN + OW'(key_code);
            ent_d = (ent_q << 4) | EW'(key_code);
            cnt_d = cnt_q + 3'd1;
          end
        end else if (key_op) begin
          op_d    = op_t'(key_code[1:0] + 2'd2);
          state_d = OP;
        end
      end
      OP: begin
        if (key_digit) begin
          b_d     = OW'(key_code);
          ent_d   = EW'(key_code);
          cnt_d   = 3'd1;
          state_d = OPB;
        end else if (key_op) begin
          op_d = op_t'(key_code[1:0] + 2'd2);
        end
      end
      OPB: begin
        if (key_digit) begin
          if (cnt_q < 3'(DIGITS)) begin
            b_d   = b_q * TEN + OW'(key_code);
            ent_d = (ent_q << 4) | EW'(key_code);
            cnt_d = cnt_q + 3'd1;
          end
        end else if (key_eq) begin
          // res doubles as the dividend/quotient shift register for division
          res_d   = RW'(a_q);
          rem_d   = '0;
          step_d  = '0;
          neg_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        state_d = CONV;
        bcd_d   = '0;
        step_d  = '0;
        case (op_q)
          OP_ADD: res_d = RW'(a_q) + b_ext;
          OP_SUB: begin
            if (a_q >= b_q) begin
              res_d = RW'(a_q) - b_ext;
            end else begin
              res_d = b_ext - RW'(a_q);
              neg_d = 1'b1;
            end
          end
          OP_MUL: res_d = RW'(a_q) * b_ext;
          default: begin
            if (b_q == '0) begin
              state_d = ERR;
            end else begin
              if (rem_sh >= {1'b0, b_ext}) begin
                rem_d = rem_sh[RW-1:0] - b_ext;
                res_d = {res_q[RW-2:0], 1'b1};
              end else begin
                rem_d = rem_sh[RW-1:0];
                res_d = {res_q[RW-2:0], 1'b0};
              end
              if (step_q != CW'(RW - 1)) begin
                state_d = CALC;
                step_d  = step_q + CW'(1);
              end
            end
          end
        endcase
      end
      CONV: begin
        bcd_d  = {bcd_adj[BW-2:0], res_q[RW-1]};
        res_d  = {res_q[RW-2:0], 1'b0};
        step_d = step_q + CW'(1);
        if (step_q == CW'(RW - 1)) begin
          state_d = SHOW;
        end
      end
      default: ;
    endcase

    // Clear wins over everything, including an in-flight computation
    if (key_clr) begin
      state_d = IDLE;
      op_d    = OP_ADD;
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      ent_d   = '0;
      res_d   = '0;
      rem_d   = '0;
      neg_d   = 1'b0;
      bcd_d   = '0;
      step_d  = '0;
    end
  end

  always_comb begin
    seg_d = BLANKS;
    msd   = 0;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) msd = i;
    end
    case (state_q)
      OPA, OPB: begin
        for (int i = 0; i < 8; i++) begin
          if (i < int'(cnt_q)) seg_d[5*i +: 5] = {1'b0, ent_pad[4*i +: 4]};
        end
      end
      OP: begin
        case (op_q)
          OP_ADD:  seg_d[9:0] = {5'd10, 5'd11};
          OP_SUB:  seg_d[4:0] = 5'd12;
          OP_MUL:  seg_d[4:0] = 5'd13;
          default: seg_d[4:0] = 5'd14;
        endcase
      end
      SHOW: begin
        // Digits above the most significant non-zero one are blanked
        for (int i = 0; i < 8; i++) begin
          if (i <= msd) seg_d[5*i +: 5] = {1'b0, bcd_q[4*i +: 4]};
          else if (neg_q && (i == msd + 1)) seg_d[5*i +: 5] = 5'd12;
        end
      end
      ERR: seg_d[14:0] = {5'd15, 5'd17, 5'd17};
      default: ;
    endcase
  end

  assign busy_d = (state_d == CALC) || (state_d == CONV);
  assign err_d  = (state_d == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      ent_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= '0;
      step_q  <= '0;
      seg_q   <= BLANKS;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      ent_q   <= ent_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign seg_data    = seg_q;
  assign seg_data_en = 8'hff;
  assign seg_dot_en  = 8'h00;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_calc_core_n.sv
// Bench for calc_core_n: two instances (DIGITS=2 and DIGITS=4) share the keypad and
// are checked against an arithmetic model of the calculator's key rules.
module tb_calc_core_n;
  localparam int RW = 27;
  localparam int M_IDLE = 0, M_OPA = 1, M_OP = 2, M_OPB = 3, M_SHOW = 4, M_ERR = 5;
  localparam logic [39:0] BLANKS = {8{5'd16}};

  logic        clk, rst_n, key_pulse;
  logic [3:0]  key_code;
  logic [39:0] seg2, seg4;
  logic [7:0]  en2, en4, dot2, dot4;
  logic        busy2, busy4, err2, err4;

  int tests_run, tests_failed;
  int m_mode[2], m_a[2], m_b[2], m_cnt[2], m_op[2], m_res[2], m_digits[2];
  bit m_neg[2];

  calc_core_n #(.DIGITS(2), .RW(RW)) dut2 (
    .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .key_code(key_code),
    .seg_data(seg2), .seg_data_en(en2), .seg_dot_en(dot2), .busy(busy2), .err(err2)
  );

  calc_core_n #(.DIGITS(4), .RW(RW)) dut4 (
    .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse), .key_code(key_code),
    .seg_data(seg4), .seg_data_en(en4), .seg_dot_en(dot4), .busy(busy4), .err(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] segOf(int idx);
    return (idx == 0) ? seg2 : seg4;
  endfunction

  function automatic logic [17:0] miscOf(int idx);
    return (idx == 0) ? {busy2, err2, en2, dot2} : {busy4, err4, en4, dot4};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_a[i] = 0; m_b[i] = 0; m_cnt[i] = 0;
      m_op[i] = 0; m_res[i] = 0; m_neg[i] = 1'b0;
    end
  endtask

  task automatic modelKey(input int idx, input int k);
    bit is_dig, is_op;
    is_dig = (k <= 9);
    is_op  = (k >= 10) && (k <= 13);
    if (k == 15) begin
      m_mode[idx] = M_IDLE; m_a[idx] = 0; m_b[idx] = 0; m_cnt[idx] = 0;
      m_op[idx] = 0; m_res[idx] = 0; m_neg[idx] = 1'b0;
      return;
    end
    case (m_mode[idx])
      M_IDLE, M_SHOW: if (is_dig) begin
        m_a[idx] = k; m_b[idx] = 0; m_cnt[idx] = 1; m_neg[idx] = 1'b0; m_mode[idx] = M_OPA;
      end
      M_OPA: begin
        if (is_dig) begin
          if (m_cnt[idx] < m_digits[idx]) begin m_a[idx] = m_a[idx] * 10 + k; m_cnt[idx]++; end
        end else if (is_op) begin
          m_op[idx] = k - 10; m_mode[idx] = M_OP;
        end
      end
      M_OP: begin
        if (is_dig) begin m_b[idx] = k; m_cnt[idx] = 1; m_mode[idx] = M_OPB; end
        else if (is_op) m_op[idx] = k - 10;
      end
      M_OPB: begin
        if (is_dig) begin
          if (m_cnt[idx] < m_digits[idx]) begin m_b[idx] = m_b[idx] * 10 + k; m_cnt[idx]++; end
        end else if (k == 14) begin
          m_mode[idx] = M_SHOW;
          m_neg[idx]  = 1'b0;
          case (m_op[idx])
            0: m_res[idx] = m_a[idx] + m_b[idx];
            1: begin
              m_neg[idx] = (m_a[idx] < m_b[idx]);
              m_res[idx] = m_neg[idx] ? m_b[idx] - m_a[idx] : m_a[idx] - m_b[idx];
            end
            2: m_res[idx] = m_a[idx] * m_b[idx];
            default: begin
              if (m_b[idx] == 0) m_mode[idx] = M_ERR;
              else m_res[idx] = m_a[idx] / m_b[idx];
            end
          endcase
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [39:0] expDisplay(int idx);
    logic [39:0] d;
    int v, p, pos;
    d = BLANKS;
    case (m_mode[idx])
      M_OPA, M_OPB: begin
        v = (m_mode[idx] == M_OPA) ? m_a[idx] : m_b[idx];
        p = 1;
        for (int i = 0; i < m_cnt[idx]; i++) begin
          d[5*i +: 5] = 5'((v / p) % 10);
          p = p * 10;
        end
      end
      M_OP: begin
        case (m_op[idx])
          0: d[9:0] = {5'd10, 5'd11};
          1: d[4:0] = 5'd12;
          2: d[4:0] = 5'd13;
          default: d[4:0] = 5'd14;
        endcase
      end
      M_SHOW: begin
        v = m_res[idx];
        pos = 0;
        do begin
          d[5*pos +: 5] = 5'(v % 10);
          v = v / 10;
          pos++;
        end while (v != 0 && pos < 8);
        if (m_neg[idx] && pos < 8) d[5*pos +: 5] = 5'd12;
      end
      M_ERR: d[14:0] = {5'd15, 5'd17, 5'd17};
      default: ;
    endcase
    return d;
  endfunction

  task automatic checkAll(input string tag);
    logic [17:0] m;
    for (int i = 0; i < 2; i++) begin
      m = miscOf(i);
      checkOutput($sformatf("%s/d%0d seg", tag, m_digits[i]), 64'(segOf(i)), 64'(expDisplay(i)));
      checkOutput($sformatf("%s/d%0d err", tag, m_digits[i]), 64'(m[16]), 64'(m_mode[i] == M_ERR));
      checkOutput($sformatf("%s/d%0d busy", tag, m_digits[i]), 64'(m[17]), 64'(0));
      checkOutput($sformatf("%s/d%0d en_dot", tag, m_digits[i]), 64'(m[15:0]), 64'(16'hff00));
    end
  endtask

  task automatic pressKey(input logic [3:0] k);
    @(negedge clk);
    key_pulse = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_pulse = 1'b0;
  endtask

  task automatic waitIdle();
    int budget;
    budget = 2 * RW + 10;
    while ((busy2 || busy4) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (busy2 || busy4) checkOutput("busy_timeout", 64'({busy2, busy4}), 64'(0));
  endtask

  task automatic applyStimulus(input logic [3:0] k);
    pressKey(k);
    for (int i = 0; i < 2; i++) modelKey(i, int'(k));
    waitIdle();
    @(negedge clk);
  endtask

  function automatic logic [3:0] keyOf(byte ch);
    case (ch)
      "+": return 4'ha;
      "-": return 4'hb;
      "*": return 4'hc;
      "/": return 4'hd;
      "=": return 4'he;
      "c": return 4'hf;
      default: return 4'(ch - "0");
    endcase
  endfunction

  task automatic applySeq(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(keyOf(s[i]));
  endtask

  task automatic equalsWithBusy(input string tag, input bit drop_keys);
    pressKey(4'he);
    checkOutput({tag, " busy d2"}, 64'(busy2), 64'(1));
    checkOutput({tag, " busy d4"}, 64'(busy4), 64'(1));
    for (int i = 0; i < 2; i++) modelKey(i, 14);
    if (drop_keys) begin
      pressKey(4'h7);
      pressKey(4'hc);
      pressKey(4'he);
      pressKey(4'h0);
    end
    waitIdle();
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    int r;
    logic [3:0] k;
    tests_run = 0;
    tests_failed = 0;
    m_digits[0] = 2;
    m_digits[1] = 4;
    modelReset();
    rst_n = 1'b0;
    key_pulse = 1'b0;
    key_code = 4'h0;
    repeat (3) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;
    @(negedge clk);

    applySeq("12+34");
    checkAll("entry_12_34");
    equalsWithBusy("add_12_34", 1'b0);
    checkOutput("add_46 const", 64'(seg2), 64'({{6{5'd16}}, 5'd4, 5'd6}));

    applySeq("c5-12");
    equalsWithBusy("sub_neg7", 1'b0);
    checkOutput("sub_neg7 const", 64'(seg4), 64'({{6{5'd16}}, 5'd12, 5'd7}));

    applySeq("c9999*9999");
    equalsWithBusy("mul_max", 1'b0);
    checkOutput("mul_max const", 64'(seg4),
                64'({5'd9, 5'd9, 5'd9, 5'd8, 5'd0, 5'd0, 5'd0, 5'd1}));

    applySeq("c7/0=");
    checkAll("div_by_zero");
    checkOutput("div_by_zero err", 64'(err2), 64'(1));
    applySeq("3");
    checkAll("err_ignores_digit");
    applySeq("c");
    checkAll("clear_from_err");

    applySeq("87/4=");
    checkAll("div_87_4");
    applySeq("9/12=");
    checkAll("div_zero_result");
    applySeq("*+-");
    checkAll("show_ignores_ops");

    applySeq("123");
    checkAll("digit_limit");
    applySeq("+5");
    equalsWithBusy("drop_during_busy", 1'b1);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60) begin
        k = 4'($urandom_range(0, 9));
        if (k == 4'h0 && (m_mode[0] == M_IDLE || m_mode[0] == M_OP || m_mode[0] == M_SHOW))
          k = 4'($urandom_range(1, 9));
      end else if (r < 80) begin
        k = 4'($urandom_range(10, 13));
      end else if (r < 93) begin
        k = 4'he;
      end else begin
        k = 4'hf;
      end
      applyStimulus(k);
      checkAll($sformatf("rand%0d", n));
    end

    applySeq("c1+2");
    pressKey(4'he);
    repeat (5) @(negedge clk);
    checkOutput("mid_conv busy", 64'(busy4), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset seg2", 64'(seg2), 64'(BLANKS));
    checkOutput("async_reset seg4", 64'(seg4), 64'(BLANKS));
    checkOutput("async_reset busy", 64'({busy2, busy4}), 64'(0));
    checkOutput("async_reset err", 64'({err2, err4}), 64'(0));
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'h5);
    checkAll("after_reset_digit");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/calc_core_n.md
CALC_CORE_N -- requirements
Module: calc_core_n

Interface
REQ-001 SHALL have parameter DIGITS, default 2, meaning the maximum number of decimal digits per operand; legal range 1..4.
REQ-002 SHALL have parameter RW, default 27, meaning the internal binary result width; RW >= 27 covers 9999*9999.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_pulse, input, 1 bit: one-cycle strobe qualifying key_code.
REQ-006 SHALL have port key_code, input, 4 bits, with this encoding:
- 0-9: digit
- a: +
- b: -
- c: *
- d: /
- e: =
- f: clear
REQ-007 SHALL have port seg_data, output, 40 bits: eight 5-bit display codes, where [4:0] is the rightmost digit.
- 0-9: digit
- 12: minus
- 15: E
- 16: blank
- 17: r
REQ-008 SHALL have port seg_data_en, output, 8 bits: per-digit enable.
REQ-009 SHALL have port seg_dot_en, output, 8 bits: per-digit decimal point.
REQ-010 SHALL have port busy, output, 1 bit: high while the block is computing or converting.
REQ-011 SHALL have port err, output, 1 bit: high while in ERR.

Function
REQ-012 SHALL implement the following states:
- IDLE
- OPA (entering operand A)
- OP (operator latched)
- OPB (entering operand B)
- CALC
- CONV
- SHOW
- ERR
REQ-013 SHALL act on a key only in the cycle key_pulse=1; keys arriving while busy=1 SHALL be dropped with no effect.
REQ-014 SHALL, on key f in any state, go to IDLE within 1 cycle, abort any computation, clear operands and set all digits blank.
REQ-015 SHALL handle keys in IDLE as follows:
- digit: A=digit, go to OPA.
- Other keys: ignored.
REQ-016 SHALL handle keys in OPA as follows:
- digit while count<DIGITS: A=A*10+digit.
- Digit while count=DIGITS: ignored.
- a-d: latch op, go to OP.
- e: ignored.
REQ-017 SHALL handle keys in OP as follows:
- digit: B=digit, go to OPB.
- a-d: replace op.
- e: ignored.
REQ-018 SHALL handle keys in OPB as follows:
- digit: accumulate under the same rule as OPA.
- e: go to CALC.
- a-d: ignored.
REQ-019 SHALL show the operand being entered right-aligned with leading blanks during OPA/OPB, and SHALL display the operator during OP:
- + on digit 0, shown as code 10 on digit 1 and 11 on digit 0.
- - shown as code 12.
- * shown as code 13.
- / shown as code 14.
REQ-020 SHALL perform CALC as follows:
- +, -, *: complete in 1 cycle.
- -: produce the magnitude |A-B| plus a negative flag.
- /: unsigned restoring division giving the integer quotient, 1 quotient bit per cycle, RW cycles.
- / with B=0: go to ERR in the cycle after entering CALC.
REQ-021 SHALL perform CONV as a binary-to-BCD double-dabble conversion of RW bits, 1 bit per cycle, then go to SHOW.
REQ-022 SHALL hold busy=1 from the cycle after e is accepted through the last CONV cycle.
REQ-023 SHALL display the result in SHOW right-aligned with leading zeros blanked; a zero result SHALL show a single 0, and a negative result SHALL place code 12 immediately left of the most significant digit.
REQ-024 SHALL handle keys in SHOW as follows:
- digit: start a new OPA with that digit; the display is cleared first.
- a-e: ignored.
REQ-025 SHALL, in ERR, display "Err" on digits 2..0 (codes 15,17,17) with the rest blank, set err=1, and leave ERR only on key f.
REQ-026 SHALL, since the result cannot overflow 8 digits for DIGITS<=4, use ERR only for divide-by-zero.
REQ-027 SHALL drive seg_data_en=8'hff and seg_dot_en=8'h00 in all states.
REQ-028 SHALL update outputs from registers only, with display outputs registered 1 cycle after the state change.

Reset
REQ-029 SHALL, while rst_n=0, immediately force:
- state=IDLE
- A=B=0
- op=+
- busy=0
- err=0
- all seg_data digits=16
- seg_data_en=8'hff
- seg_dot_en=8'h00
REQ-030 SHALL, on reset asserted mid-CALC/CONV, discard the computation; after release the block SHALL be in IDLE and accept keys on the first cycle.

Verification
REQ-031 SHALL pass: keys 1,2,+,3,4,= -> busy high, then within RW+3 cycles the display shows blanks…"46" on digits 1..0.
REQ-032 SHALL pass: 5,-,1,2,= -> the display shows "-7", with code 12 on digit 1 and 7 on digit 0.
REQ-033 SHALL pass with DIGITS=4: 9,9,9,9,*,9,9,9,9,= -> the display shows 99980001 and err=0.
REQ-034 SHALL pass: 7,/,0,= -> err=1 and the display shows "Err"; then 3 is ignored, and f gives all blanks, err=0, IDLE.
REQ-035 SHALL pass: with DIGITS=2, 1,2,3 -> the display shows "12", the third digit is ignored, and keys pressed during busy are dropped (the result is unchanged).
REQ-036 SHALL pass: rst_n pulsed low during CONV -> outputs return to reset values asynchronously, and the next digit key enters OPA.
